// File: rtl/rvfi_check_pkg.sv
// Shared types and helpers for the RVFI progress checker.
package rvfi_check_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_WAITING = 2'd2,
      ST_HALTED  = 2'd3
   } progress_state_e;

   localparam logic [31:0] WFI_ENCODING = 32'h10500073;

   // Bits needed to hold 0..bound; never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned bound);
      return (bound < 1) ? 1 : $clog2(bound + 1);
   endfunction

endpackage

// File: rtl/rvfi_retire_popcount.sv
// Counts valid retirement channels and reports the highest-index valid channel.
module rvfi_retire_popcount
   import rvfi_check_pkg::*;
#(
   parameter int NRET = 1,
   parameter int CW   = cnt_width(NRET),
   parameter int IW   = (NRET > 1) ? $clog2(NRET) : 1
) (
   input  logic [NRET-1:0] i_valid,
   output logic [CW-1:0]   o_count,
   output logic [IW-1:0]   o_last,
   output logic            o_any
);

   always_comb begin
      o_count = '0;
      o_last  = '0;
      for (int i = 0; i < NRET; i++) begin
         if (i_valid[i]) begin
            o_count = o_count + CW'(1);
            o_last  = IW'(i);
         end
      end
   end

   assign o_any = |i_valid;

endmodule

// File: rtl/rvfi_progress_check.sv
// Liveness checker on the RVFI retirement port: bounded retirement gap,
// minimum retirement count by the check strobe, and wait/halt handling.
//
//   state      | meaning
//   -----------+-------------------------------------------------------------
//   ST_IDLE    | no observation window open, counters held at 0
//   ST_ARMED   | window open, non-retiring cycles counted against MAX_GAP
//   ST_WAITING | last retirement was a wait insn, idling is legal
//   ST_HALTED  | core halted, obligation complete, any retirement is a fault
module rvfi_progress_check
   import rvfi_check_pkg::*;
#(
   parameter int          NRET       = 1,
   parameter int          ILEN       = 32,
   parameter int          MAX_GAP    = 16,
   parameter int          MIN_RET    = 1,
   parameter int          HALT_MODE  = 0,
   parameter logic [31:0] WAIT_MASK  = 32'hffffffff,
   parameter logic [31:0] WAIT_MATCH = WFI_ENCODING
) (
   input  logic                             clock,
   input  logic                             resetn,
   input  logic                             trig,
   input  logic                             check,
   input  logic [NRET-1:0]                  rvfi_valid,
   input  logic [NRET-1:0]                  rvfi_halt,
   input  logic [NRET*ILEN-1:0]             rvfi_insn,
   output logic [1:0]                       state,
   output logic [cnt_width(MIN_RET)-1:0]    ret_count,
   output logic [cnt_width(MAX_GAP)-1:0]    gap_count,
   output logic                             fail_gap,
   output logic                             fail_halt,
   output logic                             pass
);

   localparam int RCW = cnt_width(MIN_RET);
   localparam int GCW = cnt_width(MAX_GAP);
   localparam int NCW = cnt_width(NRET);
   localparam int LIW = (NRET > 1) ? $clog2(NRET) : 1;
   localparam int SW  = RCW + NCW;

   progress_state_e r_state, w_state_nxt, w_adv_state;
   logic [RCW-1:0]  r_ret, w_ret_nxt, w_ret_sat, w_base;
   logic [GCW-1:0]  r_gap, w_gap_nxt;
   logic            r_fgap, w_fgap_nxt;
   logic            r_fhalt, w_fhalt_nxt;
   logic            r_pass;
   logic [NCW-1:0]  w_n;
   logic [LIW-1:0]  w_last;
   logic            w_any;
   logic [ILEN-1:0] w_last_insn;
   logic            w_wait, w_halt, w_ok;
   logic [SW-1:0]   w_sum;

   rvfi_retire_popcount #(.NRET(NRET), .CW(NCW), .IW(LIW)) u_popcount (
      .i_valid (rvfi_valid),
      .o_count (w_n),
      .o_last  (w_last),
      .o_any   (w_any)
   );

   assign w_last_insn = rvfi_insn[int'(w_last)*ILEN +: ILEN];

   // Only the last retiring channel decides whether the core is now waiting.
   assign w_wait = w_any && (WAIT_MASK != 32'd0) &&
                   ((32'(w_last_insn) & WAIT_MASK) == WAIT_MATCH);
   assign w_halt = (HALT_MODE != 0) && (|(rvfi_valid & rvfi_halt));

   assign w_adv_state = w_halt ? ST_HALTED : (w_wait ? ST_WAITING : ST_ARMED);

   assign w_base    = (trig || r_state == ST_IDLE) ? '0 : r_ret;
   assign w_sum     = SW'(w_base) + SW'(w_n);
   assign w_ret_sat = (w_sum >= SW'(MIN_RET)) ? RCW'(MIN_RET) : w_sum[RCW-1:0];

   always_comb begin
      w_state_nxt = r_state;
      w_ret_nxt   = r_ret;
      w_gap_nxt   = r_gap;
      w_fgap_nxt  = r_fgap;
      w_fhalt_nxt = r_fhalt;
      if (trig) begin
         w_ret_nxt   = w_ret_sat;
         w_gap_nxt   = '0;
         w_state_nxt = w_adv_state;
      end else begin
         unique case (r_state)
            ST_IDLE: ;
            ST_ARMED: begin
               w_ret_nxt   = w_ret_sat;
               w_state_nxt = w_adv_state;
               if (w_any) begin
                  w_gap_nxt = '0;
               end else if (r_gap == GCW'(MAX_GAP)) begin
                  w_fgap_nxt = 1'b1;
               end else begin
                  w_gap_nxt = r_gap + GCW'(1);
               end
            end
            ST_WAITING: begin
               if (w_any) begin
                  w_ret_nxt   = w_ret_sat;
                  w_state_nxt = w_adv_state;
               end
            end
            ST_HALTED: begin
               if (w_any) w_fhalt_nxt = 1'b1;
            end
         endcase
      end
   end

   // Evaluated on post-update values so this cycle's retirements count.
   assign w_ok = (r_state != ST_IDLE) && !w_fgap_nxt && !w_fhalt_nxt &&
                 ((w_ret_nxt >= RCW'(MIN_RET)) || (w_state_nxt == ST_HALTED));

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_state <= ST_IDLE;
         r_ret   <= '0;
         r_gap   <= '0;
         r_fgap  <= 1'b0;
         r_fhalt <= 1'b0;
         r_pass  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_ret   <= w_ret_nxt;
         r_gap   <= w_gap_nxt;
         r_fgap  <= w_fgap_nxt;
         r_fhalt <= w_fhalt_nxt;
         if (check) r_pass <= w_ok;
      end
   end

   assign state     = r_state;
   assign ret_count = r_ret;
   assign gap_count = r_gap;
   assign fail_gap  = r_fgap;
   assign fail_halt = r_fhalt;
   assign pass      = r_pass;

`ifdef FORMAL
   always_comb begin
      if (resetn && check) assert (w_ok);
   end
   generate
      if (HALT_MODE == 0) begin : g_halt_assume
         always_comb begin
            if (resetn) assume (!(|(rvfi_valid & rvfi_halt)));
         end
      end
   endgenerate
`endif

`ifndef SYNTHESIS
   generate
      if (HALT_MODE == 0) begin : g_halt_error
         always @(posedge clock) begin
            if (resetn && (|(rvfi_valid & rvfi_halt)))
               $error("rvfi_progress_check: halting retirement while halts are forbidden");
         end
      end
   endgenerate
`endif

endmodule

// File: tb/tb_rvfi_progress_check.sv
// Randomized and directed bench for rvfi_progress_check against a behavioural model.
module tb_rvfi_progress_check;

   localparam int          MAX_GAP = 4;
   localparam int          MIN_RET = 2;
   localparam logic [31:0] WFI     = 32'h10500073;

   logic        clock = 1'b0;
   logic        resetn = 1'b0;
   logic        trig = 1'b0;
   logic        check = 1'b0;
   logic [1:0]  rvfi_valid = '0;
   logic [1:0]  rvfi_halt = '0;
   logic [63:0] rvfi_insn = '0;
   logic [1:0]  state;
   logic [1:0]  ret_count;
   logic [2:0]  gap_count;
   logic        fail_gap, fail_halt, pass;

   int n_tests = 0;
   int n_fail  = 0;
   int m_st, m_ret, m_gap, m_fg, m_fh, m_pass;

   rvfi_progress_check #(
      .NRET(2), .ILEN(32), .MAX_GAP(MAX_GAP), .MIN_RET(MIN_RET), .HALT_MODE(1)
   ) dut (
      .clock(clock), .resetn(resetn), .trig(trig), .check(check),
      .rvfi_valid(rvfi_valid), .rvfi_halt(rvfi_halt), .rvfi_insn(rvfi_insn),
      .state(state), .ret_count(ret_count), .gap_count(gap_count),
      .fail_gap(fail_gap), .fail_halt(fail_halt), .pass(pass)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int sat_ret(input int v);
      return (v > MIN_RET) ? MIN_RET : v;
   endfunction

   task automatic model_reset();
      m_st = 0; m_ret = 0; m_gap = 0; m_fg = 0; m_fh = 0; m_pass = 0;
   endtask

   // States: 0 idle, 1 armed, 2 waiting, 3 halted.
   task automatic model_step(input bit t, input bit c, input bit [1:0] v,
                             input bit [1:0] h, input bit [63:0] ins);
      int  n, last, old, adv;
      bit  wt, hl;
      n    = int'(v[0]) + int'(v[1]);
      last = v[1] ? 1 : 0;
      wt   = (n > 0) && (ins[last*32 +: 32] == WFI);
      hl   = (v & h) != 2'b00;
      adv  = hl ? 3 : (wt ? 2 : 1);
      old  = m_st;
      if (t) begin
         m_ret = sat_ret(n);
         m_gap = 0;
         m_st  = adv;
      end else if (m_st == 1) begin
         m_ret = sat_ret(m_ret + n);
         if (n > 0) begin
            m_gap = 0;
            m_st  = adv;
         end else if (m_gap + 1 > MAX_GAP) begin
            m_fg = 1;
         end else begin
            m_gap = m_gap + 1;
         end
      end else if (m_st == 2) begin
         if (n > 0) begin
            m_ret = sat_ret(m_ret + n);
            m_st  = adv;
         end
      end else if (m_st == 3) begin
         if (n > 0) m_fh = 1;
      end
      if (c) m_pass = (old != 0 && m_fg == 0 && m_fh == 0 &&
                       (m_ret >= MIN_RET || m_st == 3)) ? 1 : 0;
   endtask

   task automatic compare_all(input string tag);
      chk({tag, ".state"},     32'(state),     32'(m_st));
      chk({tag, ".ret_count"}, 32'(ret_count), 32'(m_ret));
      chk({tag, ".gap_count"}, 32'(gap_count), 32'(m_gap));
      chk({tag, ".fail_gap"},  32'(fail_gap),  32'(m_fg));
      chk({tag, ".fail_halt"}, 32'(fail_halt), 32'(m_fh));
      chk({tag, ".pass"},      32'(pass),      32'(m_pass));
   endtask

   // Called at a falling edge; returns at the next falling edge.
   task automatic step(input string tag, input bit t, input bit c, input bit [1:0] v,
                       input bit [1:0] h, input bit [63:0] ins);
      trig = t; check = c; rvfi_valid = v; rvfi_halt = h; rvfi_insn = ins;
      model_step(t, c, v, h, ins);
      @(posedge clock);
      #1;
      compare_all(tag);
      @(negedge clock);
   endtask

   task automatic idle(input string tag, input int k);
      for (int i = 0; i < k; i++) step(tag, 1'b0, 1'b0, 2'b00, 2'b00, 64'd0);
   endtask

   task automatic do_reset(input string tag);
      trig = 1'b0; check = 1'b0; rvfi_valid = '0; rvfi_halt = '0;
      resetn = 1'b0;
      #2;
      model_reset();
      compare_all(tag);
      @(negedge clock);
      resetn = 1'b1;
   endtask

   initial begin
      model_reset();
      @(negedge clock);
      do_reset("rst0");

      // Retire at cycles 1 and 3, check at 5.
      step("s1.trig", 1, 0, 2'b00, 2'b00, 64'd0);
      step("s1.r1",   0, 0, 2'b01, 2'b00, 64'h13);
      idle("s1.i2", 1);
      step("s1.r3",   0, 0, 2'b01, 2'b00, 64'h13);
      idle("s1.i4", 1);
      step("s1.chk",  0, 1, 2'b00, 2'b00, 64'd0);
      chk("s1.ret_const",  32'(ret_count), 32'd2);
      chk("s1.pass_const", 32'(pass),      32'd1);

      // Five idle cycles exceed MAX_GAP.
      do_reset("rst1");
      step("s2.trig", 1, 0, 2'b00, 2'b00, 64'd0);
      idle("s2.idle", 4);
      chk("s2.fg_before", 32'(fail_gap), 32'd0);
      idle("s2.idle5", 1);
      chk("s2.fg_const",  32'(fail_gap),  32'd1);
      chk("s2.gap_const", 32'(gap_count), 32'd4);
      idle("s2.more", 2);
      step("s2.chk", 0, 1, 2'b01, 2'b00, 64'h13);
      chk("s2.pass_const", 32'(pass), 32'd0);

      // Dual retirement in the trig cycle.
      do_reset("rst2");
      step("s3.trig", 1, 0, 2'b11, 2'b00, {32'h33, 32'h13});
      step("s3.chk",  0, 1, 2'b00, 2'b00, 64'd0);
      chk("s3.ret_const",  32'(ret_count), 32'd2);
      chk("s3.pass_const", 32'(pass),      32'd1);

      // WFI keeps long idle legal.
      do_reset("rst3");
      step("s4.trig", 1, 0, 2'b00, 2'b00, 64'd0);
      step("s4.wfi",  0, 0, 2'b01, 2'b00, {32'd0, WFI});
      chk("s4.st_wait", 32'(state), 32'd2);
      idle("s4.idle", 20);
      chk("s4.gap0", 32'(gap_count), 32'd0);
      step("s4.ret",  0, 0, 2'b10, 2'b00, {32'h13, 32'd0});
      chk("s4.st_armed", 32'(state),    32'd1);
      chk("s4.fg0",      32'(fail_gap), 32'd0);

      // Halt ends the obligation; later retirement is a fault.
      do_reset("rst4");
      step("s5.trig", 1, 0, 2'b00, 2'b00, 64'd0);
      step("s5.halt", 0, 0, 2'b01, 2'b01, 64'h13);
      idle("s5.idle", 10);
      step("s5.chk",  0, 1, 2'b00, 2'b00, 64'd0);
      chk("s5.st_const",   32'(state), 32'd3);
      chk("s5.pass_const", 32'(pass),  32'd1);
      step("s5.late", 0, 0, 2'b01, 2'b00, 64'h13);
      chk("s5.fh_const", 32'(fail_halt), 32'd1);

      // Asynchronous reset mid-window.
      do_reset("rst5");
      step("s6.trig", 1, 0, 2'b00, 2'b00, 64'd0);
      idle("s6.idle", 3);
      chk("s6.gap3", 32'(gap_count), 32'd3);
      do_reset("s6.rst");
      step("s6.chk", 0, 1, 2'b00, 2'b00, 64'd0);
      chk("s6.pass_const", 32'(pass), 32'd0);

      // Randomized traffic, periodically reset so flags do not stay latched.
      for (int i = 0; i < 600; i++) begin
         bit        t, c;
         bit [1:0]  v, h;
         bit [63:0] ins;
         if (i % 120 == 0) do_reset("rnd.rst");
         t = ($urandom_range(0, 99) < 5);
         c = ($urandom_range(0, 99) < 12);
         for (int k = 0; k < 2; k++) begin
            v[k] = ($urandom_range(0, 99) < 35);
            h[k] = v[k] && ($urandom_range(0, 99) < 3);
            ins[k*32 +: 32] = ($urandom_range(0, 99) < 25) ? WFI : 32'($urandom);
         end
         step("rnd", t, c, v, h, ins);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
